kart_state: RTL and testbench
=============================

# kart_state

Per-frame kart dynamics engine that produces the `direction`, `player_x` and `player_y` values consumed by the racer view renderer.
- Once per video frame it runs a short sequencer:
  - samples the four driver buttons;
  - updates heading and speed;
  - fetches sin/cos of the new heading;
  - integrates position in 11.4 fixed point;
  - reads the track tile under the kart, so sand limits top speed on the next frame.
- It shares the 360-entry sin/cos tables (signed, scaled by 512) and the 16×16 track tile map (4-bit types, 128-px tiles) used by the renderer.
- Both tables live at top level; this block only drives their addresses.

## Interface
Parameters:
- `START_X`, default 1024: reset x position in pixels.
- `START_Y`, default 1024: reset y position in pixels.
- `MAX_SPEED`, default 48: road speed cap, in 1/16 px per frame (≤127).
- `ACCEL`, default 2: speed added per frame while accelerating.
- `BRAKE`, default 4: speed removed per frame while braking.
- `FRICTION`, default 1: speed removed per frame while coasting.
- `TURN_RATE`, default 3: degrees of heading change per frame.
- `SAND_TYPE`, default 1: tile type that halves the speed cap.

Ports:
- `clk_in`  in  1  system clock. One clock domain.
- `rst_in`  in  1  reset, synchronous, active-high.
- `frame_start`  in  1  one-cycle pulse per frame.
- `btn_accel`, `btn_brake`, `btn_left`, `btn_right`  in  1 each  driver inputs, already debounced.
- `trig_addr`  out  9  heading address to the sin/cos ROMs.
- `sin_in`, `cos_in`  in  11 signed each  ROM data; valid exactly 2 cycles after `trig_addr`.
- `tile_addr`  out  8  track ROM address `{y[10:7], x[10:7]}`.
- `tile_type_in`  in  4  track ROM data; valid exactly 2 cycles after `tile_addr`.
- `direction`  out  9  heading, 0..359. 0 is screen-up (y decreasing); heading increases clockwise.
- `player_x`, `player_y`  out  11 each  integer pixel position.
- `speed_out`  out  7  current speed.
- `busy`  out  1  high while the update sequence runs.
- `update_done`  out  1  one-cycle pulse when the outputs commit.

## Operation
States: IDLE → STEER → TRIG (2 wait cycles) → MOVE → TILE (2 wait cycles) → COMMIT → IDLE.

**IDLE**
- On `frame_start`: latch the four buttons, go to STEER, raise `busy`.
- `frame_start` in any other state is ignored (no queueing).

**STEER** (heading)
- left only: `dir − TURN_RATE`, wrapping modulo 360 (0 − 3 → 357).
- right only: `dir + TURN_RATE` mod 360 (358 + 3 → 1).
- both or neither: unchanged.

**STEER** (speed)
- Brake has priority.
  - brake: `max(speed − BRAKE, 0)`.
  - else accel: `speed + ACCEL`.
  - else: `max(speed − FRICTION, 0)`.
- Then clamp to the cap. Cap is `MAX_SPEED`, or `MAX_SPEED>>1` if the stored tile type equals `SAND_TYPE`.
- A speed above a newly lowered cap drops to the cap immediately.

**TRIG**
- Drive `trig_addr` = new heading; hold it for both wait cycles.

**MOVE**
- Internal position is 15-bit unsigned 11.4 fixed point.
- dx = (speed × sin) >>> 9; dy = −((speed × cos) >>> 9).
- Products are 19-bit signed; `>>>` is arithmetic, rounding toward −∞.
- New position = old + delta, saturated to 0..32767 on each axis independently.

**TILE**
- Drive `tile_addr` from the new integer position bits [10:7]; hold it for both wait cycles.

**COMMIT**
- Store `tile_type_in`.
- Update `direction`, `player_x` (pos_x[14:4]), `player_y` and `speed_out` together in the same edge.
- Pulse `update_done`; drop `busy`.
- Outputs never change at any other time, so the renderer sees no partial updates.

**Reset**
- Values: `direction` = 0, `player_x` = `START_X`, `player_y` = `START_Y`, fractional bits 0, `speed_out` = 0, stored tile type 0, `trig_addr` = 0, `tile_addr` = 0, `busy` = 0, `update_done` = 0, state IDLE.
- Reset mid-sequence aborts the sequence with no commit.

## Timing
- `frame_start` is sampled at edge E0.
- STEER occupies cycle E0→E1; `trig_addr` is valid from E2.
- MOVE samples sin/cos at E4; `tile_addr` is valid from E5; COMMIT samples the tile at E7.
- Outputs and `update_done` are visible after E8. Total latency is 8 cycles.
- `busy` is high from E1 through E7.
- A `frame_start` at E8 (same cycle `update_done` is high) is accepted, since the FSM is back in IDLE.

## Test plan
- **Reset:** assert `rst_in` for 2 cycles → `direction`=0, `player_x`=`player_y`=1024, `speed_out`=0, `busy`=0, `update_done`=0.
- **Straight acceleration:** heading 0, ROM model returns cos=511, sin=0; one frame with accel → 8 cycles after `frame_start`:
  - `speed_out`=2, dy = −((2×511)>>>9) = −1;
  - `player_y`=1023 (16383>>4), `player_x`=1024;
  - `update_done` pulses exactly once.
- **Heading wrap:** left for one frame from 0 → `direction`=357. Then right for two frames → 0, then 3. Both buttons held → unchanged.
- **Sand cap:**
  - Accelerate to 48 on a road tile; the tile model then returns `SAND_TYPE`.
  - Next frame with accel → `speed_out`=24.
  - Brake+accel together → 20 (brake wins).
- **Edge clamp:** start near x=0 at heading 270 with the model sin=−512; speed 48 for 30 frames → `player_x` saturates at 0 and never wraps to 2047. Repeat at the opposite edge → 2047.
- **Busy and reset:**
  - Extra `frame_start` pulses at E3 and E6 → ignored; exactly one commit.
  - `rst_in` asserted at E5 → no `update_done`, all outputs return to reset values.

Source files
------------

// File: rtl/kart_state.sv
// Per-frame kart dynamics: steer, fetch sin/cos, integrate 11.4 position, read tile under kart.
// Latency 8 cycles from frame_start to committed outputs; frame_start is ignored while busy.
module kart_state #(
  parameter int START_X   = 1024,
  parameter int START_Y   = 1024,
  parameter int MAX_SPEED = 48,
  parameter int ACCEL     = 2,
  parameter int BRAKE     = 4,
  parameter int FRICTION  = 1,
  parameter int TURN_RATE = 3,
  parameter int SAND_TYPE = 1
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               frame_start,
  input  logic               btn_accel,
  input  logic               btn_brake,
  input  logic               btn_left,
  input  logic               btn_right,
  output logic [8:0]         trig_addr,
  input  logic signed [10:0] sin_in,
  input  logic signed [10:0] cos_in,
  output logic [7:0]         tile_addr,
  input  logic [3:0]         tile_type_in,
  output logic [8:0]         direction,
  output logic [10:0]        player_x,
  output logic [10:0]        player_y,
  output logic [6:0]         speed_out,
  output logic               busy,
  output logic               update_done
);

  typedef enum logic [3:0] {
    S_IDLE, S_STEER, S_TRIG, S_TRIG_WAIT, S_MOVE,
    S_TILE, S_TILE_WAIT, S_TILE_READ, S_COMMIT
  } state_t;

  localparam logic [14:0] RST_X = {11'(START_X), 4'b0};
  localparam logic [14:0] RST_Y = {11'(START_Y), 4'b0};

  state_t      state_q, state_d;
  logic [3:0]  btn_q, btn_d;              // {accel, brake, left, right}
  logic [8:0]  dir_q, dir_d, dir_n_q, dir_n_d;
  logic [6:0]  spd_q, spd_d, spd_n_q, spd_n_d;
  logic [14:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [14:0] pos_x_n_q, pos_x_n_d, pos_y_n_q, pos_y_n_d;
  logic [3:0]  tile_q, tile_d;
  logic [8:0]  trig_addr_q, trig_addr_d;
  logic [7:0]  tile_addr_q, tile_addr_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic [9:0]  hdg_sum;
  logic [8:0]  hdg_new;
  logic [8:0]  spd_raw, spd_cap;
  logic [6:0]  spd_new;
  logic signed [18:0] spd_ext, sin_ext, cos_ext, prod_x, prod_y, dx, dy, sum_x, sum_y;

  function automatic logic [14:0] sat15(input logic signed [18:0] v);
    if (v < 19'sd0)          return 15'd0;
    else if (v > 19'sd32767) return 15'h7fff;
    else                     return v[14:0];
  endfunction

  always_comb begin
    hdg_sum = {1'b0, dir_q};
    if (btn_q[1] && !btn_q[0])      hdg_sum = {1'b0, dir_q} + 10'(360 - TURN_RATE);
    else if (btn_q[0] && !btn_q[1]) hdg_sum = {1'b0, dir_q} + 10'(TURN_RATE);
    if (hdg_sum >= 10'd360) hdg_sum = hdg_sum - 10'd360;
    hdg_new = hdg_sum[8:0];
  end

  // The cap uses the tile stored last frame, so it also pulls an over-cap speed down at once.
  always_comb begin
    spd_cap = (tile_q == 4'(SAND_TYPE)) ? 9'(MAX_SPEED >> 1) : 9'(MAX_SPEED);
    if (btn_q[2])
      spd_raw = ({2'b0, spd_q} >= 9'(BRAKE)) ? {2'b0, spd_q} - 9'(BRAKE) : 9'd0;
    else if (btn_q[3])
      spd_raw = {2'b0, spd_q} + 9'(ACCEL);
    else
      spd_raw = ({2'b0, spd_q} >= 9'(FRICTION)) ? {2'b0, spd_q} - 9'(FRICTION) : 9'd0;
    spd_new = (spd_raw > spd_cap) ? spd_cap[6:0] : spd_raw[6:0];
  end

  always_comb begin
    spd_ext = {12'b0, spd_n_q};
    sin_ext = {{8{sin_in[10]}}, sin_in};
    cos_ext = {{8{cos_in[10]}}, cos_in};
    prod_x  = spd_ext * sin_ext;
    prod_y  = spd_ext * cos_ext;
    dx      = prod_x >>> 9;
    dy      = -(prod_y >>> 9);
    sum_x   = {4'b0, pos_x_q} + dx;
    sum_y   = {4'b0, pos_y_q} + dy;
  end

  always_comb begin
    state_d     = state_q;
    btn_d       = btn_q;
    dir_d       = dir_q;
    dir_n_d     = dir_n_q;
    spd_d       = spd_q;
    spd_n_d     = spd_n_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    pos_x_n_d   = pos_x_n_q;
    pos_y_n_d   = pos_y_n_q;
    tile_d      = tile_q;
    trig_addr_d = trig_addr_q;
    tile_addr_d = tile_addr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          btn_d   = {btn_accel, btn_brake, btn_left, btn_right};
          busy_d  = 1'b1;
          state_d = S_STEER;
        end
      end
      S_STEER: begin
        dir_n_d = hdg_new;
        spd_n_d = spd_new;
        state_d = S_TRIG;
      end
      S_TRIG: begin
        trig_addr_d = dir_n_q;
        state_d     = S_TRIG_WAIT;
      end
      S_TRIG_WAIT: state_d = S_MOVE;
      S_MOVE: begin
        pos_x_n_d = sat15(sum_x);
        pos_y_n_d = sat15(sum_y);
        state_d   = S_TILE;
      end
      S_TILE: begin
        tile_addr_d = {pos_y_n_q[14:11], pos_x_n_q[14:11]};
        state_d     = S_TILE_WAIT;
      end
      S_TILE_WAIT: state_d = S_TILE_READ;
      S_TILE_READ: begin
        tile_d  = tile_type_in;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        dir_d   = dir_n_q;
        spd_d   = spd_n_q;
        pos_x_d = pos_x_n_q;
        pos_y_d = pos_y_n_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      btn_q       <= 4'd0;
      dir_q       <= 9'd0;
      dir_n_q     <= 9'd0;
      spd_q       <= 7'd0;
      spd_n_q     <= 7'd0;
      pos_x_q     <= RST_X;
      pos_y_q     <= RST_Y;
      pos_x_n_q   <= RST_X;
      pos_y_n_q   <= RST_Y;
      tile_q      <= 4'd0;
      trig_addr_q <= 9'd0;
      tile_addr_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn_d;
      dir_q       <= dir_d;
      dir_n_q     <= dir_n_d;
      spd_q       <= spd_d;
      spd_n_q     <= spd_n_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      pos_x_n_q   <= pos_x_n_d;
      pos_y_n_q   <= pos_y_n_d;
      tile_q      <= tile_d;
      trig_addr_q <= trig_addr_d;
      tile_addr_q <= tile_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign trig_addr   = trig_addr_q;
  assign tile_addr   = tile_addr_q;
  assign direction   = dir_q;
  assign player_x    = pos_x_q[14:4];
  assign player_y    = pos_y_q[14:4];
  assign speed_out   = spd_q;
  assign busy        = busy_q;
  assign update_done = done_q;

endmodule

// File: tb/tb_kart_state.sv
// Directed bench for kart_state with a 2-cycle sin/cos ROM model and a switchable sand tile map.
module tb_kart_state;

  logic               clk_in = 1'b0;
  logic               rst_in = 1'b1;
  logic               frame_start = 1'b0;
  logic               btn_accel = 1'b0, btn_brake = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic [8:0]         trig_addr;
  logic signed [10:0] sin_in, cos_in;
  logic [7:0]         tile_addr;
  logic [3:0]         tile_type_in;
  logic [8:0]         direction;
  logic [10:0]        player_x, player_y;
  logic [6:0]         speed_out;
  logic               busy, update_done;

  kart_state dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_start(frame_start),
    .btn_accel(btn_accel), .btn_brake(btn_brake), .btn_left(btn_left), .btn_right(btn_right),
    .trig_addr(trig_addr), .sin_in(sin_in), .cos_in(cos_in),
    .tile_addr(tile_addr), .tile_type_in(tile_type_in),
    .direction(direction), .player_x(player_x), .player_y(player_y),
    .speed_out(speed_out), .busy(busy), .update_done(update_done)
  );

  always #5 clk_in = ~clk_in;

  // ROM model: address registered once, data combinational -> usable 2 edges after the address.
  logic [8:0] trig_rom_q;
  logic       sand_mode = 1'b0;
  always @(posedge clk_in) trig_rom_q <= trig_addr;
  always_comb begin
    sin_in = 11'sd0;
    cos_in = 11'sd0;
    case (trig_rom_q)
      9'd0:    cos_in = 11'sd511;
      9'd90:   sin_in = 11'sd511;
      9'd180:  cos_in = -11'sd512;
      9'd270:  sin_in = -11'sd512;
      default: ;
    endcase
  end
  assign tile_type_in = sand_mode ? 4'd1 : 4'd0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int         lat, done_cnt;
  logic [8:0] trig_seen;
  logic [7:0] tile_seen;
  logic       busy_e1, busy_e7, busy_e8;

  // One frame: pulse sampled at E0, then observe 12 cycles (each sample half a cycle after E_k).
  task automatic frame(input logic a, input logic b, input logic l, input logic r, input bit extra);
    @(negedge clk_in);
    {btn_accel, btn_brake, btn_left, btn_right} = {a, b, l, r};
    frame_start = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
    lat = 0;
    done_cnt = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_in);
      if (k == 1) busy_e1 = busy;
      if (k == 2) trig_seen = trig_addr;
      if (k == 5) tile_seen = tile_addr;
      if (k == 7) busy_e7 = busy;
      if (k == 8) busy_e8 = busy;
      if (update_done) begin
        done_cnt++;
        if (lat == 0) lat = k;
      end
      frame_start = extra && (k == 2 || k == 5);
    end
    frame_start = 1'b0;
    {btn_accel, btn_brake, btn_left, btn_right} = 4'b0;
  endtask

  initial begin
    int prev;
    int rst_done;

    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    check("rst_dir", direction, 0);
    check("rst_x", player_x, 1024);
    check("rst_y", player_y, 1024);
    check("rst_speed", speed_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", update_done, 0);

    // Straight acceleration at heading 0 (cos=511)
    frame(1, 0, 0, 0, 0);
    check("acc_lat", lat, 8);
    check("acc_done_cnt", done_cnt, 1);
    check("acc_speed", speed_out, 2);
    check("acc_y", player_y, 1023);
    check("acc_x", player_x, 1024);
    check("acc_busy_e1", busy_e1, 1);
    check("acc_busy_e7", busy_e7, 1);
    check("acc_busy_e8", busy_e8, 0);
    check("acc_tile_addr", tile_seen, 8'h78);

    // Heading wrap
    frame(0, 0, 1, 0, 0);
    check("left_dir", direction, 357);
    check("left_trig", trig_seen, 357);
    check("left_speed", speed_out, 1);
    frame(0, 0, 0, 1, 0);
    check("right1_dir", direction, 0);
    frame(0, 0, 0, 1, 0);
    check("right2_dir", direction, 3);
    check("right2_trig", trig_seen, 3);
    check("right2_speed", speed_out, 0);
    // Both held, with extra frame_start pulses at E3 and E6
    frame(0, 0, 1, 1, 1);
    check("both_dir", direction, 3);
    check("busy_extra_done_cnt", done_cnt, 1);

    // Sand cap
    repeat (24) frame(1, 0, 0, 0, 0);
    check("road_speed", speed_out, 48);
    sand_mode = 1'b1;
    frame(1, 0, 0, 0, 0);
    check("road_last_speed", speed_out, 48);
    frame(1, 0, 0, 0, 0);
    check("sand_speed", speed_out, 24);
    frame(1, 1, 0, 0, 0);
    check("sand_brake_speed", speed_out, 20);
    sand_mode = 1'b0;

    // Turn to 270 while braking to a stop
    repeat (31) frame(0, 1, 1, 0, 0);
    check("west_dir", direction, 270);
    check("west_speed0", speed_out, 0);

    // Drive west into x=0
    prev = int'(player_x);
    for (int i = 0; i < 380; i++) begin
      frame(1, 0, 0, 0, 0);
      check("west_done", done_cnt, 1);
      check("west_no_wrap", (int'(player_x) <= prev), 1);
      prev = int'(player_x);
    end
    check("west_x", player_x, 0);
    check("west_speed", speed_out, 48);

    // Turn to 90 and drive east into x=2047
    repeat (60) frame(1, 0, 0, 1, 0);
    check("east_dir", direction, 90);
    prev = int'(player_x);
    for (int i = 0; i < 720; i++) begin
      frame(1, 0, 0, 0, 0);
      check("east_no_wrap", (int'(player_x) >= prev), 1);
      prev = int'(player_x);
    end
    check("east_x", player_x, 2047);

    // Reset at E5 aborts the frame
    @(negedge clk_in);
    btn_left = 1'b1;
    btn_accel = 1'b1;
    frame_start = 1'b1;
    @(negedge clk_in);
    frame_start = 1'b0;
    rst_done = 0;
    repeat (4) begin
      @(negedge clk_in);
      if (update_done) rst_done++;
    end
    rst_in = 1'b1;
    repeat (2) @(negedge clk_in);
    rst_in = 1'b0;
    {btn_accel, btn_left} = 2'b0;
    repeat (12) begin
      @(negedge clk_in);
      if (update_done) rst_done++;
    end
    check("abort_no_done", rst_done, 0);
    check("abort_dir", direction, 0);
    check("abort_x", player_x, 1024);
    check("abort_y", player_y, 1024);
    check("abort_speed", speed_out, 0);
    check("abort_busy", busy, 0);
    check("abort_trig", trig_addr, 0);
    check("abort_tile", tile_addr, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
